// File: rtl/mux_arbiter.sv
// Two-requester round-robin burst arbiter driving the select of a shared 2:1 data mux.
// Bursts run back-to-back; the winner of the next burst is picked on the last accepted beat.
module mux_arbiter #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [LEN_W-1:0] len_a,
    input  logic [WIDTH-1:0] a,
    input  logic             req_b,
    input  logic [LEN_W-1:0] len_b,
    input  logic [WIDTH-1:0] b,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             s,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             ack_a,
    output logic             ack_b
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_A,
        GNT_B
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic             last;

    logic beat;
    logic rearb;
    logic anyreq;
    logic pickb;

    assign beat   = out_valid & ready;
    assign rearb  = (state == IDLE) | (beat & (cnt == '0));
    assign anyreq = req_a | req_b;
    // On a tie the requester that was not granted last wins.
    assign pickb  = req_b & (~req_a | ~last);

    assign out   = s ? b : a;
    assign ack_a = gnt_a & ready;
    assign ack_b = gnt_b & ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            s         <= 1'b0;
            out_valid <= 1'b0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
        end else if (rearb) begin
            if (anyreq) begin
                state     <= pickb ? GNT_B : GNT_A;
                cnt       <= pickb ? len_b : len_a;
                last      <= pickb;
                s         <= pickb;
                out_valid <= 1'b1;
                gnt_a     <= ~pickb;
                gnt_b     <= pickb;
            end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                gnt_a     <= 1'b0;
                gnt_b     <= 1'b0;
            end
        end else if (beat) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

endmodule
